// File: rtl/ns_codec_pkg.sv
// ---------------------------------------------------------------------------
// ns_codec_pkg
// Shared definitions for the one-hot / binary codec group.
//   - MAX_ONE_HOT_WIDTH / MAX_BIN_WIDTH : widest vector the helpers handle
//   - calc_bin_width()                  : binary index width for a vector
//   - onehot_decode()                   : binary index -> {vec, err}
//   - skid_state_t                      : occupancy states of the skid buffer
// ---------------------------------------------------------------------------
package ns_codec_pkg;

    localparam int MAX_ONE_HOT_WIDTH = 64;
    localparam int MAX_BIN_WIDTH     = 6;

    // Width of a binary index addressing a vector of 'width' bits. A 2-bit
    // vector still needs one index bit, so never return less than 1.
    function automatic int calc_bin_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Decodes a binary index into a one-hot vector of 'width' live bits.
    // Result layout is {vec, err}, so callers can truncate the result to
    // their own width+1 and keep {vec[width-1:0], err}. Indices at or above
    // 'width' give an all-zero vector with err set.
    function automatic logic [MAX_ONE_HOT_WIDTH:0] onehot_decode(
        input logic [MAX_BIN_WIDTH-1:0] bin,
        input int                       width
    );
        logic [MAX_ONE_HOT_WIDTH-1:0] vec;
        logic                         err;
        if (int'(bin) < width) begin
            vec = {{(MAX_ONE_HOT_WIDTH-1){1'b0}}, 1'b1} << bin;
            err = 1'b0;
        end else begin
            vec = '0;
            err = 1'b1;
        end
        return {vec, err};
    endfunction

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ns_bin2onehot_pipe_if.sv
// ---------------------------------------------------------------------------
// ns_bin2onehot_pipe_if
// Handshake bundle of the binary-to-one-hot decoder.
//   in_valid/in_ready/bin_code         : binary index stream into the block
//   out_valid/out_ready/one_hot_code/
//   out_err                            : decoded stream out of the block
// Modports:
//   master : the environment (drives indices and out_ready)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface ns_bin2onehot_pipe_if
    import ns_codec_pkg::*;
#(
    parameter int ONE_HOT_WIDTH = 8
);

    localparam int BIN_WIDTH = calc_bin_width(ONE_HOT_WIDTH);

    logic                     in_valid;
    logic                     in_ready;
    logic [BIN_WIDTH-1:0]     bin_code;
    logic                     out_valid;
    logic                     out_ready;
    logic [ONE_HOT_WIDTH-1:0] one_hot_code;
    logic                     out_err;

    modport master (
        output in_valid,
        output bin_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  one_hot_code,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  bin_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output one_hot_code,
        output out_err
    );

endinterface

// File: rtl/ns_skid_buf.sv
// ---------------------------------------------------------------------------
// ns_skid_buf
// Two-entry skid buffer: an output register plus one skid register, so the
// upstream sees a registered in_ready and the stream still moves one word
// per cycle when the downstream is always ready.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake (in_ready is a flop)
//   in_data              : word accepted on in_valid & in_ready
//   out_valid/out_ready  : downstream handshake
//   out_data             : word at the head of the buffer
// ---------------------------------------------------------------------------
module ns_skid_buf
    import ns_codec_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    skid_state_t           state_q;
    skid_state_t           state_d;
    logic                  in_ready_q;
    logic                  in_ready_d;
    logic [DATA_WIDTH-1:0] out_reg_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  load_out_from_in;
    logic                  load_out_from_skid;
    logic                  load_skid;
    logic                  accept;
    logic                  xfer;

    assign accept    = in_valid & in_ready_q;
    assign xfer      = (state_q != BUF_EMPTY) & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = out_reg_q;

    // Next-state and register-load decisions. The output register is always
    // the head of the FIFO; the skid register only fills when a word arrives
    // while the head is stalled. in_ready for the next cycle is taken from
    // the next state, which keeps out_ready off any combinational path to
    // in_ready while still reopening the input one cycle after a drain.
    always_comb begin
        state_d            = state_q;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d          = BUF_ONE;
                    load_out_from_in = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && xfer) begin
                    load_out_from_in = 1'b1;
                end else if (accept) begin
                    state_d   = BUF_FULL;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (xfer) begin
                    state_d            = BUF_ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        in_ready_d = (state_d != BUF_FULL);
    end

    // State, ready flop and the two data registers. Reset drops every
    // buffered word and holds in_ready low for the first cycle afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b0;
            out_reg_q  <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_out_from_in) begin
                out_reg_q <= in_data;
            end else if (load_out_from_skid) begin
                out_reg_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ns_bin2onehot_pipe.sv
// ---------------------------------------------------------------------------
// ns_bin2onehot_pipe
// Pipelined binary-to-one-hot decoder with a 2-entry skid buffer and a
// saturating debug counter of out-of-range indices.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : handshake bundle (slave side), see ns_bin2onehot_pipe_if
//   err_clr   : clears err_cnt (an error accepted in the same cycle counts 1)
//   err_cnt   : saturating count of accepted out-of-range indices
// ---------------------------------------------------------------------------
module ns_bin2onehot_pipe
    import ns_codec_pkg::*;
#(
    parameter int ONE_HOT_WIDTH = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ns_bin2onehot_pipe_if.slave      bus,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int BIN_WIDTH = calc_bin_width(ONE_HOT_WIDTH);
    localparam int ENTRY_W   = ONE_HOT_WIDTH + 1;

    logic [BIN_WIDTH-1:0] bin_idx;
    logic [ENTRY_W-1:0]   entry_in;
    logic [ENTRY_W-1:0]   entry_out;
    logic                 err_inc;

    // Decoding happens before the buffer, so each stored entry is already
    // {one_hot_code, out_err}; truncating the wide helper result keeps
    // exactly the live vector bits plus the error flag.
    assign bin_idx  = bus.bin_code;
    assign entry_in = ENTRY_W'(onehot_decode(MAX_BIN_WIDTH'(bin_idx), ONE_HOT_WIDTH));
    assign err_inc  = bus.in_valid & bus.in_ready & entry_in[0];

    ns_skid_buf #(
        .DATA_WIDTH (ENTRY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (entry_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (entry_out)
    );

    assign bus.one_hot_code = entry_out[ENTRY_W-1:1];
    assign bus.out_err      = entry_out[0];

    // Error counter counts at accept time, so output backpressure has no
    // effect on it. A clear coinciding with an error leaves that error
    // counted, and the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= err_inc ? ERR_CNT_WIDTH'(1) : '0;
        end else if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/ns_bin2onehot_pipe.md
Name: ns_bin2onehot_pipe

Overview:
- Pipelined binary-to-one-hot decoder; the inverse of the one-hot-to-binary converter in the same codec group.
- Accepts a stream of binary indices on a valid/ready handshake and emits one-hot vectors on a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput under backpressure.
- Flags out-of-range indices (ONE_HOT_WIDTH not a power of two) and counts them for debug.

Parameters:
ONE_HOT_WIDTH, 8, width of the one-hot output vector; legal range 2..64.
BIN_WIDTH, $clog2(ONE_HOT_WIDTH), localparam, width of the binary input.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  bin_code valid.
in_ready  out  1  block can accept bin_code this cycle.
bin_code  in  BIN_WIDTH  binary index to decode.
out_valid  out  1  one_hot_code/out_err valid.
out_ready  in  1  downstream accepts output this cycle.
one_hot_code  out  ONE_HOT_WIDTH  decoded vector, bit[bin_code] set.
out_err  out  1  entry was out of range; one_hot_code is all zeros.
err_clr  in  1  clears err_cnt.
err_cnt  out  ERR_CNT_WIDTH  saturating count of accepted out-of-range indices.

Behaviour:
- Reset values (while rst high and on the first cycle after): in_ready=0, out_valid=0, one_hot_code=0, out_err=0, err_cnt=0, both buffer entries empty. in_ready rises the cycle after rst falls.
- Accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Latency: an accepted index appears on the outputs the next cycle if the output register is empty or is transferring that cycle.
- Decode:
  - bin_code < ONE_HOT_WIDTH -> one_hot_code = 1 << bin_code, out_err=0.
  - Otherwise -> one_hot_code = 0, out_err=1.
  - Decode happens on entry into the buffer; stored entries are {one_hot_code, out_err}.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register valid, skid empty, in_ready=1.
  - FULL: both valid, in_ready=0.
- Transitions:
  - EMPTY+accept -> ONE.
  - ONE+accept+transfer -> ONE (output reg reloaded).
  - ONE+accept+no transfer -> FULL (new entry into skid).
  - ONE+transfer only -> EMPTY.
  - FULL+transfer -> ONE (skid moves to output reg).
  - No accept is possible in FULL.
- in_ready is a registered signal: no combinational path from out_ready to in_ready.
- Ordering is strictly FIFO. Outputs hold stable while out_valid=1 and out_ready=0.
- Throughput: 1 transfer per cycle when out_ready is held high.
- err_cnt:
  - Increments on each accept of an out-of-range index; saturates at all-ones.
  - err_clr alone -> 0. err_clr with a simultaneous increment -> 1.
  - Not affected by output backpressure.
- Reset mid-operation: all buffered entries are discarded with no output transfer; reset values apply the next cycle.
- in_valid while in_ready=0 is ignored; the upstream must hold it.

Decomposition:
- Shared package ns_codec_pkg:
  - function onehot_decode(bin, width) returning {vec, err}.
  - localparam helper for BIN_WIDTH computation.
  - The existing one-hot-to-binary converter also uses this package.
- Sub-module ns_skid_buf, parameterised on data width and instantiated with width ONE_HOT_WIDTH+1. It holds the EMPTY/ONE/FULL state machine and the registered in_ready.
- Top level contains the decode function call, err_cnt, and the ns_skid_buf instance.

Test Plan:
1. Reset, then bin_code 0..7 back-to-back with out_ready=1 -> one_hot_code 8'h01,02,04,...,80 one cycle after each accept, out_valid continuous, out_err=0.
2. Accept 3 and 5 with out_ready=0 -> buffer FULL, in_ready=0, one_hot_code=8'h08 held. Raise out_ready -> 8'h08 then 8'h20 in order. in_ready returns to 1 a cycle later.
3. ONE_HOT_WIDTH=6, send 4,6,7,2 -> outputs 6'h10; 0 with out_err=1; 0 with out_err=1; 6'h04. err_cnt=2.
4. ERR_CNT_WIDTH=2, ONE_HOT_WIDTH=6, send 5 out-of-range indices -> err_cnt saturates at 3. err_clr coincident with the next error accept -> err_cnt=1.
5. Assert rst with the buffer FULL -> out_valid=0, in_ready=0, err_cnt=0 the next cycle. No stale vector appears after reset release.
6. Random in_valid/out_ready at 50% for 10k cycles -> scoreboard FIFO order matches, no loss or duplication, outputs stable under stall.
